i2s_fifo_tx: RTL and testbench
==============================

I2S_FIFO_TX -- requirements
Module: i2s_fifo_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 8, meaning CLK cycles per BCLK half-period (legal range 2..255).
REQ-002 SHALL have port CLK, input, 1 bit: system clock.
REQ-003 SHALL have port RESET, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port RUN, input, 1 bit: enable serial output.
REQ-005 SHALL have port FIFO_EMPTY, input, 1 bit: sample FIFO has no data.
REQ-006 SHALL have port FIFO_DATA, input, 32 bits: signed sample word, valid the CLK cycle after RD_FIFO.
REQ-007 SHALL have port RD_FIFO, output, 1 bit: one-CLK read strobe to the sample FIFO.
REQ-008 SHALL have port BCLK, output, 1 bit: I2S bit clock.
REQ-009 SHALL have port LRCLK, output, 1 bit: I2S word select, 0 = left, 1 = right.
REQ-010 SHALL have port SDATA, output, 1 bit: I2S serial data.
REQ-011 SHALL have port UNDERRUN, output, 1 bit: one-CLK pulse on a missed fetch.

Function
REQ-012 SHALL use a divider counter 0..BCLK_DIV-1 that advances every CLK while active; BCLK SHALL toggle when the counter wraps.
REQ-013 A falling-edge event SHALL be a BCLK 1->0 toggle; LRCLK, SDATA and the 6-bit bit counter (0..63, wraps) SHALL change only on falling-edge events.
REQ-014 LRCLK SHALL be 0 for bit counter values 0..31 and 1 for values 32..63, giving 64 BCLK per frame.
REQ-015 Framing SHALL be standard I2S with one-bit delay:
- left word MSB on SDATA at count 1, left LSB at count 32;
- right word MSB at count 33, right LSB at count 0 of the next frame.
REQ-016 The block is mono: the same 32-bit word SHALL be sent on both left and right.
REQ-017 A fetch SHALL occur on the falling-edge event where the count becomes 48:
- if FIFO_EMPTY=0, RD_FIFO SHALL pulse high for exactly one CLK;
- FIFO_DATA SHALL be captured the next CLK into a pending register.
REQ-018 On the falling-edge event where the count becomes 0, the pending word SHALL be transferred to the transmit shift register.
REQ-019 If FIFO_EMPTY=1 at the fetch point, RD_FIFO SHALL stay 0, UNDERRUN SHALL pulse for one CLK, and the pending word SHALL take the underrun value (see Configuration).
REQ-020 At most one RD_FIFO pulse SHALL occur per frame, and RD_FIFO SHALL never assert while FIFO_EMPTY=1.
REQ-021 The state machine SHALL have three states:
- IDLE: BCLK=0, LRCLK=0, SDATA=0, counters cleared, no reads.
- PRIME: issue one fetch immediately if the FIFO is non-empty, else load the underrun value.
- ACTIVE: normal serialisation.
REQ-022 Transitions:
- IDLE->PRIME when RUN=1;
- PRIME->ACTIVE once the pending word is captured (at most 2 CLK), after which the first frame starts at count 0;
- ACTIVE->IDLE on the count 63->0 wrap when RUN=0.
REQ-023 If RUN drops mid-frame, the current frame SHALL complete and no further fetches SHALL occur after the wrap.
REQ-024 If RUN rises again during the frame it would end, the block SHALL stay in ACTIVE without a gap.
REQ-025 Divider and bit counter widths SHALL be 8 and 6 bits, and both SHALL wrap without overflow effects.

Reset
REQ-026 On RESET assertion, regardless of the current state, the block SHALL immediately enter IDLE.
REQ-027 During reset: BCLK=0, LRCLK=0, SDATA=0, RD_FIFO=0, UNDERRUN=0; shift, pending and last-sample registers SHALL be 0; all counters SHALL be 0.
REQ-028 After RESET deasserts, the block SHALL restart only via the IDLE->PRIME path.

Configuration
REQ-029 Macro I2S_HOLD_LAST_EN:
- when defined, the underrun value SHALL be the last successfully read sample (0 after reset);
- when undefined, the underrun value SHALL be 32'h00000000 (mute).
UNDERRUN pulsing SHALL be identical in both builds.

Verification
REQ-030 BCLK_DIV=2, RUN=1, FIFO holding 32'h80000001 then 32'h7FFFFFFF -> frame 1 SDATA carries 1000...0001 in both slots per REQ-015, then 0111...1 in frame 2; BCLK period = 4 CLK; LRCLK period = 256 CLK.
REQ-031 FIFO held non-empty for 10 frames -> exactly 10 RD_FIFO pulses, each one CLK wide, each at the count-48 falling edge; UNDERRUN never asserts.
REQ-032 FIFO empty at the fetch of frame 3, last sample 32'h12345678 -> UNDERRUN single pulse, no RD_FIFO, frame 4 sends 32'h12345678 with I2S_HOLD_LAST_EN and 32'h0 without it.
REQ-033 RUN deasserted at count 20 -> frame completes to count 63, block enters IDLE with outputs 0, no fetch after that frame; RUN reasserted -> PRIME then output starts at count 0.
REQ-034 RESET asserted at count 40 mid-right-slot -> all outputs 0 asynchronously in the same cycle; after release with RUN=1, the first fetch occurs in PRIME.
REQ-035 FIFO_EMPTY toggling every CLK across the fetch point -> RD_FIFO is never high while FIFO_EMPTY=1, and each frame has exactly one RD_FIFO or one UNDERRUN, never both.

Source files
------------

// File: rtl/i2s_fifo_tx.sv
// i2s_fifo_tx: mono 32-bit I2S transmitter that pulls one sample per frame from a FIFO.
// Define I2S_HOLD_LAST_EN to repeat the last good sample on underrun instead of muting.
module i2s_fifo_tx #(
  parameter int BCLK_DIV = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RUN,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_DATA,
  output logic        RD_FIFO,
  output logic        BCLK,
  output logic        LRCLK,
  output logic        SDATA,
  output logic        UNDERRUN
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, ACTIVE = 2'd2} state_t;

  localparam logic [7:0] DIV_MAX   = 8'(BCLK_DIV - 1);
  localparam logic [5:0] FETCH_CNT = 6'd48;

  state_t      state_r, state_s;
  logic [7:0]  div_cnt_r, div_cnt_s;
  logic [5:0]  bit_cnt_r, bit_cnt_s;
  logic        bclk_r, bclk_s;
  logic        lrclk_r, lrclk_s;
  logic        sdata_r, sdata_s;
  logic        fetch_r, fetch_s;
  logic        cap_r, cap_s;
  logic        underrun_r, underrun_s;
  logic [31:0] shift_r, shift_s;
  logic [31:0] pending_r, pending_s;
  logic [31:0] und_val_s;
  logic [5:0]  bit_nxt_s, bit_neg_s;
  logic        rd_s, miss_s, div_wrap_s;

`ifdef I2S_HOLD_LAST_EN
  logic [31:0] last_r;

  // Remember the most recent sample actually delivered by the FIFO
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_r <= 32'h0000_0000;
    end else if (cap_r) begin
      last_r <= FIFO_DATA;
    end
  end

  assign und_val_s = last_r;
`else
  assign und_val_s = 32'h0000_0000;
`endif

  // The read strobe is qualified by the live empty flag so it can never overlap FIFO_EMPTY
  assign rd_s       = fetch_r & ~FIFO_EMPTY;
  assign miss_s     = fetch_r & FIFO_EMPTY;
  assign div_wrap_s = (div_cnt_r == DIV_MAX);
  assign bit_nxt_s  = bit_cnt_r + 6'd1;
  // Lower 5 bits of -count give the bit index for both slots with the one-bit I2S delay
  assign bit_neg_s  = 6'd0 - bit_nxt_s;

  assign RD_FIFO  = rd_s;
  assign BCLK     = bclk_r;
  assign LRCLK    = lrclk_r;
  assign SDATA    = sdata_r;
  assign UNDERRUN = underrun_r;

  // Next-state and datapath decode for the IDLE/PRIME/ACTIVE sequencer
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = div_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    bclk_s     = bclk_r;
    lrclk_s    = lrclk_r;
    sdata_s    = sdata_r;
    shift_s    = shift_r;
    fetch_s    = 1'b0;
    cap_s      = rd_s;
    underrun_s = miss_s;
    if (cap_r) begin
      pending_s = FIFO_DATA;
    end else if (miss_s) begin
      pending_s = und_val_s;
    end else begin
      pending_s = pending_r;
    end

    case (state_r)
      IDLE: begin
        div_cnt_s = 8'd0;
        bit_cnt_s = 6'd0;
        bclk_s    = 1'b0;
        lrclk_s   = 1'b0;
        sdata_s   = 1'b0;
        if (RUN) begin
          state_s = PRIME;
          fetch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      PRIME: begin
        if (cap_r || miss_s) begin
          state_s = ACTIVE;
          shift_s = pending_s;
        end else begin
          state_s = PRIME;
        end
      end
      ACTIVE: begin
        if (!div_wrap_s) begin
          div_cnt_s = div_cnt_r + 8'd1;
        end else if (!bclk_r) begin
          div_cnt_s = 8'd0;
          bclk_s    = 1'b1;
        end else begin
          div_cnt_s = 8'd0;
          bclk_s    = 1'b0;
          bit_cnt_s = bit_nxt_s;
          lrclk_s   = bit_nxt_s[5];
          sdata_s   = shift_r[bit_neg_s[4:0]];
          if (bit_nxt_s == FETCH_CNT) begin
            fetch_s = 1'b1;
          end else if (bit_nxt_s != 6'd0) begin
            fetch_s = 1'b0;
          end else if (RUN) begin
            shift_s = pending_r;
          end else begin
            state_s = IDLE;
            lrclk_s = 1'b0;
            sdata_s = 1'b0;
          end
        end
      end
      default: begin
        state_s   = IDLE;
        div_cnt_s = 8'd0;
        bit_cnt_s = 6'd0;
        bclk_s    = 1'b0;
        lrclk_s   = 1'b0;
        sdata_s   = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= IDLE;
      div_cnt_r  <= 8'd0;
      bit_cnt_r  <= 6'd0;
      bclk_r     <= 1'b0;
      lrclk_r    <= 1'b0;
      sdata_r    <= 1'b0;
      fetch_r    <= 1'b0;
      cap_r      <= 1'b0;
      underrun_r <= 1'b0;
      shift_r    <= 32'h0000_0000;
      pending_r  <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      bclk_r     <= bclk_s;
      lrclk_r    <= lrclk_s;
      sdata_r    <= sdata_s;
      fetch_r    <= fetch_s;
      cap_r      <= cap_s;
      underrun_r <= underrun_s;
      shift_r    <= shift_s;
      pending_r  <= pending_s;
    end
  end

endmodule

// File: tb/tb_i2s_fifo_tx.sv
// Directed self-checking bench for i2s_fifo_tx (BCLK_DIV=2) with a behavioural FIFO and I2S recorder.
module tb_i2s_fifo_tx;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        RUN = 1'b0;
  logic        FIFO_EMPTY = 1'b1;
  logic [31:0] FIFO_DATA = 32'h0;
  logic        RD_FIFO, BCLK, LRCLK, SDATA, UNDERRUN;

  int checks = 0;
  int errors = 0;

  i2s_fifo_tx #(.BCLK_DIV(2)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
    .RD_FIFO(RD_FIFO), .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA), .UNDERRUN(UNDERRUN)
  );

  always #5 CLK = ~CLK;

  logic [31:0] fifo_q[$];
  logic        toggle_mode = 1'b0;
  logic [1:0]  bits_q[$];
  int          rd_pos_q[$], und_pos_q[$], bclk_rise_q[$], lr_rise_q[$];
  int          rd_hi = 0, und_hi = 0, viol = 0, cyc = 0;
  logic        bclk_prev = 1'b0, lr_prev = 1'b0, rd_prev = 1'b0, und_prev = 1'b0, rd_flag = 1'b0;

  // Recorder: one entry {LRCLK,SDATA} per BCLK falling edge, plus strobe positions
  always @(negedge CLK) begin
    cyc++;
    if (bclk_prev && !BCLK) bits_q.push_back({LRCLK, SDATA});
    if (!bclk_prev && BCLK) bclk_rise_q.push_back(cyc);
    if (!lr_prev && LRCLK) lr_rise_q.push_back(cyc);
    if (RD_FIFO) begin
      rd_hi++;
      if (!rd_prev) rd_pos_q.push_back(bits_q.size());
    end
    if (UNDERRUN) begin
      und_hi++;
      if (!und_prev) und_pos_q.push_back(bits_q.size());
    end
    if (RD_FIFO && FIFO_EMPTY) viol++;
    bclk_prev = BCLK;
    lr_prev   = LRCLK;
    rd_prev   = RD_FIFO;
    und_prev  = UNDERRUN;
    rd_flag   = RD_FIFO;
  end

  // FIFO model: data appears the cycle after a read strobe
  always @(posedge CLK) begin
    #1;
    if (rd_flag && fifo_q.size() > 0) FIFO_DATA = fifo_q.pop_front();
    FIFO_EMPTY = toggle_mode ? ~FIFO_EMPTY : (fifo_q.size() == 0);
  end

  function automatic logic [31:0] left_word(input int base);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[31-i] = bits_q[base+i][0];
    return w;
  endfunction

  function automatic logic [31:0] right_word(input int base);
    logic [31:0] w;
    for (int i = 0; i < 31; i++) w[31-i] = bits_q[base+32+i][0];
    w[0] = bits_q[base+63][0];
    return w;
  endfunction

  function automatic int lr_bad(input int base);
    int n = 0;
    for (int i = 0; i < 64; i++)
      if (bits_q[base+i][1] !== ((i >= 31) && (i <= 62))) n++;
    return n;
  endfunction

  task automatic clear_rec();
    bits_q.delete(); rd_pos_q.delete(); und_pos_q.delete();
    bclk_rise_q.delete(); lr_rise_q.delete();
    rd_hi = 0; und_hi = 0; viol = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; RUN = 1'b0; toggle_mode = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    fifo_q.delete();
    clear_rec();
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_bits(input int n, input string tag);
    int k = 0;
    while (bits_q.size() < n && k < 5000) begin
      @(posedge CLK); #2; k++;
    end
    checks++;
    if (bits_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d bits, need %0d", tag, bits_q.size(), n);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if ({BCLK, LRCLK, SDATA, RD_FIFO, UNDERRUN} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {BCLK, LRCLK, SDATA, RD_FIFO, UNDERRUN});
    end
    do_reset();
    repeat (10) @(posedge CLK);
    #2;
    checks++;
    if (rd_pos_q.size() != 0 || bits_q.size() != 0 || BCLK !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: reads %0d bits %0d bclk %b expected 0 0 0", rd_pos_q.size(), bits_q.size(), BCLK);
    end
  endtask

  task automatic test_frames();
    int p;
    do_reset();
    fifo_q.push_back(32'h8000_0001); fifo_q.push_back(32'h7FFF_FFFF); fifo_q.push_back(32'hA5A5_0F0F);
    repeat (2) @(posedge CLK);
    #2; RUN = 1'b1;
    wait_bits(128, "frames");
    chk32("f1_left", left_word(0), 32'h8000_0001);
    chk32("f1_right", right_word(0), 32'h8000_0001);
    chk32("f2_left", left_word(64), 32'h7FFF_FFFF);
    chk32("f2_right", right_word(64), 32'h7FFF_FFFF);
    chk32("f1_lrclk_bad", 32'(lr_bad(0)), 32'd0);
    p = (bclk_rise_q.size() >= 2) ? bclk_rise_q[1] - bclk_rise_q[0] : -1;
    chk32("bclk_period", 32'(p), 32'd4);
    p = (lr_rise_q.size() >= 2) ? lr_rise_q[1] - lr_rise_q[0] : -1;
    chk32("lrclk_period", 32'(p), 32'd256);
    chk32("frames_rd_count", 32'(rd_pos_q.size()), 32'd3);
    if (rd_pos_q.size() == 3) begin
      chk32("frames_rd_pos1", 32'(rd_pos_q[1]), 32'd48);
      chk32("frames_rd_pos2", 32'(rd_pos_q[2]), 32'd112);
    end
    chk32("frames_und_count", 32'(und_pos_q.size()), 32'd0);
    RUN = 1'b0;
  endtask

  task automatic test_steady();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 20; i++) fifo_q.push_back(32'h1000_0000 + 32'(i));
    repeat (2) @(posedge CLK);
    #2; RUN = 1'b1;
    wait_bits(640, "steady");
    chk32("steady_rd_count", 32'(rd_pos_q.size()), 32'd11);
    if (rd_pos_q.size() == 11) begin
      if (rd_pos_q[0] != 0) bad++;
      for (int k = 1; k < 11; k++) if (rd_pos_q[k] != 64*(k-1) + 48) bad++;
    end
    chk32("steady_rd_pos_bad", 32'(bad), 32'd0);
    chk32("steady_rd_width", 32'(rd_hi), 32'd11);
    chk32("steady_und_count", 32'(und_pos_q.size()), 32'd0);
    chk32("steady_f10_left", left_word(576), 32'h1000_0009);
    RUN = 1'b0;
  endtask

  task automatic test_underrun();
    logic [31:0] exp_w;
`ifdef I2S_HOLD_LAST_EN
    exp_w = 32'h1234_5678;
`else
    exp_w = 32'h0000_0000;
`endif
    do_reset();
    fifo_q.push_back(32'h1111_1111); fifo_q.push_back(32'h2222_2222); fifo_q.push_back(32'h1234_5678);
    repeat (2) @(posedge CLK);
    #2; RUN = 1'b1;
    wait_bits(256, "underrun");
    chk32("und_f3_left", left_word(128), 32'h1234_5678);
    chk32("und_f4_left", left_word(192), exp_w);
    chk32("und_f4_right", right_word(192), exp_w);
    chk32("und_rd_count", 32'(rd_pos_q.size()), 32'd3);
    chk32("und_pulses", 32'(und_pos_q.size()), 32'd2);
    if (und_pos_q.size() > 0) chk32("und_pos", 32'(und_pos_q[0]), 32'd176);
    chk32("und_width", 32'(und_hi), 32'd2);
    RUN = 1'b0;
  endtask

  task automatic test_run_drop();
    int k = 0;
    do_reset();
    fifo_q.push_back(32'hC0FF_EE01); fifo_q.push_back(32'hDEAD_BEEF); fifo_q.push_back(32'h0BAD_F00D);
    repeat (2) @(posedge CLK);
    #2; RUN = 1'b1;
    wait_bits(20, "drop_c20");
    RUN = 1'b0;
    wait_bits(64, "drop_end");
    repeat (20) @(posedge CLK);
    #2;
    chk32("drop_bits_stop", 32'(bits_q.size()), 32'd64);
    chk32("drop_idle_out", {29'd0, BCLK, LRCLK, SDATA}, 32'd0);
    chk32("drop_left", left_word(0), 32'hC0FF_EE01);
    chk32("drop_right_hi", right_word(0) & 32'hFFFF_FFFE, 32'hC0FF_EE00);
    chk32("drop_last_entry", {30'd0, bits_q[63]}, 32'd0);
    chk32("drop_rd_count", 32'(rd_pos_q.size()), 32'd2);
    RUN = 1'b1;
    while (rd_pos_q.size() < 3 && k < 20) begin @(posedge CLK); #2; k++; end
    chk32("restart_rd_count", 32'(rd_pos_q.size()), 32'd3);
    if (rd_pos_q.size() == 3) chk32("restart_rd_pos", 32'(rd_pos_q[2]), 32'd64);
    wait_bits(96, "restart");
    chk32("restart_left", left_word(64), 32'h0BAD_F00D);
    RUN = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset();
    fifo_q.push_back(32'h5555_AAAA); fifo_q.push_back(32'h3C3C_F0F0); fifo_q.push_back(32'h0F0F_0F0F);
    repeat (2) @(posedge CLK);
    #2; RUN = 1'b1;
    wait_bits(40, "mid_c40");
    chk32("mid_lrclk_right", {31'd0, LRCLK}, 32'd1);
    RESET = 1'b1;
    #1;
    chk32("mid_async_out", {27'd0, BCLK, LRCLK, SDATA, RD_FIFO, UNDERRUN}, 32'd0);
    repeat (2) @(posedge CLK);
    #2;
    clear_rec();
    @(negedge CLK);
    RESET = 1'b0;
    while (rd_pos_q.size() < 1 && k < 20) begin @(posedge CLK); #2; k++; end
    chk32("mid_prime_rd", 32'(rd_pos_q.size()), 32'd1);
    if (rd_pos_q.size() == 1) chk32("mid_prime_pos", 32'(rd_pos_q[0]), 32'd0);
    wait_bits(32, "mid_restart");
    chk32("mid_left", left_word(0), 32'h3C3C_F0F0);
    RUN = 1'b0;
  endtask

  task automatic test_empty_toggle();
    int exp_pos[5] = '{0, 48, 112, 176, 240};
    int hits[5] = '{0, 0, 0, 0, 0};
    int bad = 0;
    do_reset();
    for (int i = 0; i < 10; i++) fifo_q.push_back(32'hABC0_0000 + 32'(i));
    repeat (2) @(posedge CLK);
    #2; toggle_mode = 1'b1; RUN = 1'b1;
    wait_bits(256, "toggle");
    chk32("toggle_viol", 32'(viol), 32'd0);
    chk32("toggle_events", 32'(rd_pos_q.size() + und_pos_q.size()), 32'd5);
    foreach (rd_pos_q[i]) for (int k = 0; k < 5; k++) if (rd_pos_q[i] == exp_pos[k]) hits[k]++;
    foreach (und_pos_q[i]) for (int k = 0; k < 5; k++) if (und_pos_q[i] == exp_pos[k]) hits[k]++;
    for (int k = 0; k < 5; k++) if (hits[k] != 1) bad++;
    chk32("toggle_one_per_fetch", 32'(bad), 32'd0);
    chk32("toggle_widths", 32'(rd_hi + und_hi), 32'(rd_pos_q.size() + und_pos_q.size()));
    RUN = 1'b0;
    toggle_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_steady();
    test_underrun();
    test_run_drop();
    test_reset_mid();
    test_empty_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
